// File: rtl/matrix_scan.sv
// Row-multiplexed display scan driver: captures a frame image into a shadow
// buffer at frame boundaries and shifts it out serially one row at a time.
module matrix_scan #(
  parameter int DATA_SIZE   = 8192,
  parameter int ROWS        = 16,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_SIZE-1:0]     data,
  input  logic                     load,
  output logic                     ser_data,
  output logic                     ser_clk,
  output logic                     ser_latch,
  output logic [$clog2(ROWS)-1:0]  row_sel,
  output logic                     blank,
  output logic                     frame_done
);

  localparam int ROW_BITS = DATA_SIZE / ROWS;
  localparam int ROW_W    = $clog2(ROWS);
  localparam int BIT_W    = $clog2(ROW_BITS);
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDX_W    = $clog2(DATA_SIZE);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(ROW_BITS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {SHIFT, LATCH, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [DATA_SIZE-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 shown_q, shown_d;
  logic                 ser_data_q, ser_data_d;
  logic                 ser_clk_q, ser_clk_d;
  logic                 ser_latch_q, ser_latch_d;
  logic [ROW_W-1:0]     row_sel_q, row_sel_d;
  logic                 blank_q, blank_d;
  logic                 frame_done_q, frame_done_d;

  logic                 capture;
  logic [DATA_SIZE-1:0] src;
  logic [IDX_W-1:0]     idx;
  logic [ROW_W-1:0]     next_row;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    shown_d      = shown_q;
    ser_data_d   = ser_data_q;
    ser_clk_d    = 1'b0;
    ser_latch_d  = 1'b0;
    row_sel_d    = row_sel_q;
    blank_d      = ~shown_q;
    frame_done_d = 1'b0;

    // The first bit of row 0 must come from the freshly captured image.
    capture  = (state_q == SHIFT) && (row_q == '0) && (bit_q == '0) && !phase_q
               && (pending_q || load);
    src      = capture ? data : shadow_q;
    idx      = IDX_W'(row_q) * IDX_W'(ROW_BITS) + IDX_W'(ROW_BITS - 1) - IDX_W'(bit_q);
    next_row = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);

    if (capture) begin
      shadow_d  = data;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    case (state_q)
      SHIFT: begin
        if (!phase_q) begin
          ser_data_d = src[idx];
          phase_d    = 1'b1;
        end else begin
          ser_clk_d = 1'b1;
          phase_d   = 1'b0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = LATCH;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      LATCH: begin
        ser_latch_d  = 1'b1;
        blank_d      = 1'b1;
        row_sel_d    = row_q;
        frame_done_d = (row_q == LAST_ROW);
        shown_d      = 1'b1;
        hold_d       = '0;
        if (HOLD_CYCLES == 0) begin
          state_d = SHIFT;
          row_d   = next_row;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == LAST_HOLD) begin
          state_d = SHIFT;
          row_d   = next_row;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SHIFT;
      row_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      hold_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      shown_q      <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_latch_q  <= 1'b0;
      row_sel_q    <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      shown_q      <= shown_d;
      ser_data_q   <= ser_data_d;
      ser_clk_q    <= ser_clk_d;
      ser_latch_q  <= ser_latch_d;
      row_sel_q    <= row_sel_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_data   = ser_data_q;
  assign ser_clk    = ser_clk_q;
  assign ser_latch  = ser_latch_q;
  assign row_sel    = row_sel_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Display scan driver that sits directly downstream of the SPI frame reader. It takes the assembled `DATA_SIZE`-bit frame image, captures it into a shadow buffer at a frame boundary, and scans it out one row at a time. Each row is shifted serially into the segment shift-register chain, latched, and then held while its row driver is selected. The shadow buffer guarantees that a frame update from the SPI side never tears a scan in progress.

## Interface
Parameters:
- `DATA_SIZE`, 8192: frame image width in bits.
- `ROWS`, 16: number of multiplexed rows. Must divide `DATA_SIZE`.
- `ROW_BITS`, `DATA_SIZE/ROWS` (512): bits shifted per row. Derived; not overridden.
- `HOLD_CYCLES`, 64: extra display cycles per row after latch. 0 is legal.

Ports:
- `clk`  in  1  system clock. Every register updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data`  in  `DATA_SIZE`  frame image from the SPI reader. Row r occupies `data[r*ROW_BITS +: ROW_BITS]`.
- `load`  in  1  single-cycle strobe: `data` is complete and stable.
- `ser_data`  out  1  serial segment data, MSB of the row first.
- `ser_clk`  out  1  shift clock for the segment chain. Chain samples on the rising edge.
- `ser_latch`  out  1  storage-register latch pulse, one cycle wide.
- `row_sel`  out  `$clog2(ROWS)`  index of the row currently displayed.
- `blank`  out  1  high disables all row drivers.
- `frame_done`  out  1  one-cycle pulse when the last row is latched.

## Operation
- Registers:
  - shadow buffer, `DATA_SIZE` bits
  - `pending` flag
  - row counter, 0..`ROWS-1`
  - bit counter, 0..`ROW_BITS-1`
  - phase bit
  - hold counter
  - state: `SHIFT`, `LATCH`, `HOLD`
- Load capture:
  - A `load` pulse sets `pending`.
  - In the first `SHIFT` cycle of row 0, if `pending` (or `load`) is set: shadow <= `data`, and `pending` clears.
  - If `load` arrives in that same capture cycle, the current `data` is captured and `pending` stays 0.
  - `load` at any other time only sets `pending`. Repeated loads before capture collapse into one; the last `data` value at capture time wins.
- `SHIFT`:
  - Two cycles per bit.
  - Phase 0: `ser_clk`=0, `ser_data` = shadow bit `r*ROW_BITS + (ROW_BITS-1-b)`.
  - Phase 1: `ser_clk`=1, `ser_data` unchanged.
  - After phase 1 of b = `ROW_BITS-1`, go to `LATCH`.
  - The previously latched row keeps displaying during `SHIFT`.
- `LATCH`, one cycle:
  - `ser_latch`=1, `blank`=1, `row_sel` <= r.
  - `frame_done`=1 if r = `ROWS-1`.
  - Then go to `HOLD`.
- `HOLD`:
  - `blank`=0 for `HOLD_CYCLES` cycles.
  - Then r <= r+1, wrapping `ROWS-1` -> 0, and go to `SHIFT` with b=0, phase 0.
  - With `HOLD_CYCLES`=0, `LATCH` goes directly to the next `SHIFT`.
- Blanking:
  - `blank` stays 1 from reset until the first `LATCH` completes.
  - After that, `blank` is 1 only during `LATCH` cycles.

## Timing
- Reset values: `ser_data`=0, `ser_clk`=0, `ser_latch`=0, `row_sel`=0, `blank`=1, `frame_done`=0, shadow=0, `pending`=0.
- After reset, state is `SHIFT`, r=0, b=0, phase 0.
- First `SHIFT` cycle is the first clock edge with `rst_n`=1. That cycle is also a capture opportunity.
- Row period: 2·`ROW_BITS` + 1 + `HOLD_CYCLES` cycles.
- Frame period: `ROWS` × row period.
- Load-to-display latency:
  - Worst case is one frame period plus one row period.
  - Minimum: `load` in the row-0 capture cycle is displayed at the `LATCH` of row 0, 2·`ROW_BITS` cycles later.
- `ser_data` changes only on phase-0 cycles. This gives one full `clk` cycle of setup and hold around each rising `ser_clk`.
- `ser_latch` is asserted only while `ser_clk`=0.
- Reset mid-operation: all outputs return to their reset values on the next edge. A partially shifted row is abandoned, and the scan restarts at row 0.
- Outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
Common bench parameters: `DATA_SIZE`=32, `ROWS`=4, `HOLD_CYCLES`=2. Row period is 19 cycles; frame period is 76 cycles.

1. Reset, no `load`:
   - `ser_data` is 0 for all 128 shifts.
   - `blank` is 1 for cycles 0–16, 0 from cycle 17 except on `LATCH` cycles.
   - `row_sel` sequence is 0,1,2,3,0.
2. `data`=32'hA5C3_0FF0 with `load` on cycle 0 after reset:
   - Row 0 shifts bits 7..0 of 0xF0 = 1,1,1,1,0,0,0,0.
   - Row 3 shifts 0xA5 MSB first.
   - `frame_done` pulses on cycle 16+3·19 = 73.
3. `load` on cycle 10 with `data`=32'h1, then `data`=32'h2 with `load` on cycle 40:
   - Frame 1 shows all zeros.
   - Frame 2 (capture at cycle 76) shows 32'h2.
   - `pending` is 0 after capture.
4. `load` exactly in the cycle-76 capture cycle:
   - That cycle's `data` is captured.
   - No further capture occurs at cycle 152.
5. `rst_n` low for one cycle during row-2 shifting:
   - Next cycle: `blank`=1, `row_sel`=0, `ser_clk`=0.
   - Scan restarts at row 0.
   - The shadow buffer is cleared.
6. `HOLD_CYCLES`=0:
   - Row period is 17 cycles.
   - `LATCH` is followed immediately by `ser_clk` low with the next row's MSB.
